// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter, one bit retired per shift_en tick.
module piso_shift_tx #(
   parameter int WIDTH      = 4,
   parameter bit MSB_FIRST  = 1'b0,
   parameter bit IDLE_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   input  logic             abort,
   output logic             sout,
   output logic             sout_valid,
   output logic             first_bit,
   output logic             last_bit,
   output logic             done,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic sout_q, sout_d, valid_q, valid_d, first_q, first_d, last_q, last_d, done_q, done_d;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         sr_q    <= '0;
         cnt_q   <= '0;
         sout_q  <= IDLE_LEVEL;
         valid_q <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         sout_q  <= sout_d;
         valid_q <= valid_d;
         first_q <= first_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   // Abort outranks both a load in IDLE and a bit tick in SHIFT.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (state_q == IDLE) begin
         if (load_valid && !abort) begin
            state_d = SHIFT;
            sr_d    = din;
            cnt_d   = '0;
         end
      end else if (abort) begin
         state_d = IDLE;
      end else if (shift_en) begin
         if (cnt_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
            sr_d  = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
         end
      end
      sout_d  = (state_d == SHIFT) ? (MSB_FIRST ? sr_d[WIDTH-1] : sr_d[0]) : IDLE_LEVEL;
      valid_d = (state_d == SHIFT);
      first_d = (state_d == SHIFT) && (cnt_d == '0);
      last_d  = (state_d == SHIFT) && (cnt_d == LAST);
   end
   assign load_ready = (state_q == IDLE);
   assign busy       = (state_q == SHIFT);
   assign sout       = sout_q;
   assign sout_valid = valid_q;
   assign first_bit  = first_q;
   assign last_bit   = last_q;
   assign done       = done_q;
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: directed checks of piso_shift_tx in LSB-first and MSB-first builds.
module tb_piso_shift_tx;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [3:0] din = '0;
   logic load_valid = 1'b0, shift_en = 1'b0, abort = 1'b0;
   logic sout0, sv0, fb0, lb0, dn0, bsy0, rdy0;
   logic sout1, sv1, fb1, lb1, dn1, bsy1, rdy1;
   int vecs = 0, errs = 0;
   always #5 clk = ~clk;
   piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid), .load_ready(rdy0),
      .shift_en(shift_en), .abort(abort), .sout(sout0), .sout_valid(sv0), .first_bit(fb0),
      .last_bit(lb0), .done(dn0), .busy(bsy0));
   piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid), .load_ready(rdy1),
      .shift_en(shift_en), .abort(abort), .sout(sout1), .sout_valid(sv1), .first_bit(fb1),
      .last_bit(lb1), .done(dn1), .busy(bsy1));
   // {sout, sout_valid, first_bit, last_bit, done, busy, load_ready}
   wire [6:0] o0 = {sout0, sv0, fb0, lb0, dn0, bsy0, rdy0};
   wire [6:0] o1 = {sout1, sv1, fb1, lb1, dn1, bsy1, rdy1};
   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      logic [3:0] pat;
      step();
      step();
      chk("reset_lsb", o0, 7'b1000001);
      chk("reset_msb", o1, 7'b1000001);
      rst_n = 1'b1;
      step();
      // LSB-first 4'b1011 with shift_en held high
      din = 4'b1011; load_valid = 1'b1; shift_en = 1'b1;
      step();
      load_valid = 1'b0;
      chk("t2_bit0", o0, 7'b1110010);
      step();
      chk("t2_bit1", o0, 7'b1100010);
      step();
      chk("t2_bit2", o0, 7'b0100010);
      step();
      chk("t2_bit3", o0, 7'b1101010);
      step();
      chk("t2_done", o0, 7'b1000101);
      step();
      chk("t2_idle", o0, 7'b1000001);
      // MSB-first 4'hA, a tick every third cycle
      shift_en = 1'b0; din = 4'hA; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      pat = 4'b1010;
      for (int k = 0; k < 4; k++)
         for (int j = 0; j < 3; j++) begin
            shift_en = (j == 2);
            chk($sformatf("t3_bit%0d_hold%0d", k, j), {3'b0, sout1, sv1, fb1, lb1},
                {3'b0, pat[3-k], 1'b1, k == 0, k == 3});
            step();
         end
      shift_en = 1'b0;
      chk("t3_done", o1, 7'b1000101);
      step();
      chk("t3_idle", o1, 7'b1000001);
      // back-to-back 4'h3 then 4'hC; load_valid and din change during SHIFT
      shift_en = 1'b1; din = 4'h3; load_valid = 1'b1;
      step();
      din = 4'hC;
      pat = 4'h3;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_f1_bit%0d", i), {sout0, bsy0, rdy0, 4'b0}, {pat[i], 2'b10, 4'b0});
         step();
      end
      chk("t4_gap_done", o0, 7'b1000101);
      step();
      load_valid = 1'b0;
      pat = 4'hC;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t4_f2_bit%0d", i), {sout0, bsy0, fb0, lb0, 3'b0},
             {pat[i], 1'b1, i == 0, i == 3, 3'b0});
         step();
      end
      chk("t4_f2_done", o0, 7'b1000101);
      // abort after second bit of 4'h5, with shift_en also high
      din = 4'h5; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      chk("t5_bit0", o0, 7'b1110010);
      step();
      chk("t5_bit1", o0, 7'b0100010);
      abort = 1'b1;
      step();
      chk("t5_aborted", o0, 7'b1000001);
      abort = 1'b0;
      step();
      chk("t5_no_done", o0, 7'b1000001);
      // abort in IDLE beats a simultaneous load
      abort = 1'b1; load_valid = 1'b1; din = 4'h6;
      step();
      chk("t5_idle_abort", o0, 7'b1000001);
      abort = 1'b0;
      step();
      load_valid = 1'b0;
      pat = 4'h6;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t5_f6_bit%0d", i), {sout0, sv0, 5'b0}, {pat[i], 1'b1, 5'b0});
         step();
      end
      chk("t5_f6_done", o0, 7'b1000101);
      // asynchronous reset mid-frame, between edges
      din = 4'h9; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      step();
      chk("t6_bit1", o0, 7'b0100010);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_lsb", o0, 7'b1000001);
      chk("t6_async_msb", o1, 7'b1000001);
      step();
      rst_n = 1'b1;
      step();
      chk("t6_no_done", o0, 7'b1000001);
      din = 4'hF; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t6_fF_bit%0d", i), {sout0, sv0, 5'b0}, 7'b1100000);
         step();
      end
      chk("t6_fF_done", o0, 7'b1000101);
      step();
      chk("t6_final_idle", o0, 7'b1000001);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
